// File: rtl/tile_stream_engine.sv
// Tile stream engine: streams a TILE x TILE tile element-by-element from
// SRAM A and SRAM B, applies ADD/SUB/EMUL per element or a MAC reduction,
// and writes the shifted, optionally saturated result to SRAM C.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       begin operation (sampled in IDLE only)
//   op_code                     0 ADD, 1 SUB, 2 EMUL, 3 MAC, 4-7 illegal
//   tile_i, tile_j              tile row/column index
//   shift, sat_en               arithmetic right shift, saturate enable
//   sram_{a,b}_re/_addr/_dout   read ports, dout valid RD_LAT cycles after re
//   sram_c_we/_addr/_din        write port
//   busy, done, err             status; done/err are one-cycle pulses
module tile_stream_engine #(
  parameter int DW         = 8,
  parameter int AW         = 10,
  parameter int TILE       = 4,
  parameter int ROW_STRIDE = 32,
  parameter int RD_LAT     = 1,
  parameter int TW         = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op_code,
  input  logic [TW-1:0] tile_i,
  input  logic [TW-1:0] tile_j,
  input  logic [3:0]    shift,
  input  logic          sat_en,
  output logic          sram_a_re,
  output logic [AW-1:0] sram_a_addr,
  input  logic [DW-1:0] sram_a_dout,
  output logic          sram_b_re,
  output logic [AW-1:0] sram_b_addr,
  input  logic [DW-1:0] sram_b_dout,
  output logic          sram_c_we,
  output logic [AW-1:0] sram_c_addr,
  output logic [DW-1:0] sram_c_din,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int N    = TILE * TILE;
  localparam int ACCW = 2 * DW + $clog2(N);
  localparam int CNTW = $clog2(N + 1);
  localparam int RCW  = (TILE > 1) ? $clog2(TILE) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MAC = 3'd3;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ACCWR, FIN} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             op_q, op_d;
  logic [3:0]             shift_q, shift_d;
  logic                   sat_q, sat_d;
  logic [AW-1:0]          base_q, base_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [RCW-1:0]         row_q, row_d, col_q, col_d;
  logic                   re_q, re_d;
  logic [AW-1:0]          rd_addr_q, rd_addr_d;
  logic [RD_LAT-1:0]      vld_q, vld_d;
  logic [AW-1:0]          paddr_q [RD_LAT];
  logic [AW-1:0]          paddr_d [RD_LAT];
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   we_q, we_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [DW-1:0]          wr_data_q, wr_data_d;
  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic signed [DW-1:0]   a_s, b_s;
  logic signed [DW:0]     sum, diff;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] elem_v;
  logic [AW-1:0]          base_new, base_sel, issue_addr;
  logic [RCW-1:0]         row_sel, col_sel, row_nx, col_nx;

  // Floor shift, then clamp to the signed DW range or keep the low DW bits.
  function automatic logic [DW-1:0] scale(input logic signed [ACCW-1:0] v,
                                          input logic [3:0] sh, input logic sat);
    logic signed [ACCW-1:0] s;
    s = v >>> sh;
    if (sat && (s > SAT_MAX)) return SAT_MAX[DW-1:0];
    if (sat && (s < SAT_MIN)) return SAT_MIN[DW-1:0];
    return s[DW-1:0];
  endfunction

  always_comb begin
    a_s  = sram_a_dout;
    b_s  = sram_b_dout;
    sum  = (DW+1)'(a_s) + (DW+1)'(b_s);
    diff = (DW+1)'(a_s) - (DW+1)'(b_s);
    prod = (2*DW)'(a_s) * (2*DW)'(b_s);
    case (op_q)
      OP_ADD:  elem_v = ACCW'(sum);
      OP_SUB:  elem_v = ACCW'(diff);
      default: elem_v = ACCW'(prod);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    shift_d   = shift_q;
    sat_d     = sat_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    re_d      = 1'b0;
    rd_addr_d = rd_addr_q;
    acc_d     = acc_q;
    we_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    vld_d[0]   = re_q;
    paddr_d[0] = rd_addr_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_d[i]   = vld_q[i-1];
      paddr_d[i] = paddr_q[i-1];
    end

    base_new = AW'(32'(tile_i) * 32'(TILE * ROW_STRIDE) + 32'(tile_j) * 32'(TILE));

    // The first read is issued from IDLE with the freshly computed base, so
    // the address generator takes its operands from either source.
    if (state_q == IDLE) begin
      base_sel = base_new;
      row_sel  = '0;
      col_sel  = '0;
    end else begin
      base_sel = base_q;
      row_sel  = row_q;
      col_sel  = col_q;
    end
    issue_addr = AW'(32'(base_sel) + 32'(row_sel) * 32'(ROW_STRIDE) + 32'(col_sel));
    if (32'(col_sel) == TILE - 1) begin
      row_nx = row_sel + RCW'(1);
      col_nx = '0;
    end else begin
      row_nx = row_sel;
      col_nx = col_sel + RCW'(1);
    end

    if (vld_q[RD_LAT-1]) begin
      if (op_q == OP_MAC) begin
        acc_d = acc_q + ACCW'(prod);
      end else begin
        we_d      = 1'b1;
        wr_addr_d = paddr_q[RD_LAT-1];
        wr_data_d = scale(elem_v, shift_q, sat_q);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_code;
          shift_d = shift;
          sat_d   = sat_en;
          base_d  = base_new;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = ISSUE;
          if (!op_code[2]) begin
            re_d      = 1'b1;
            rd_addr_d = issue_addr;
            row_d     = row_nx;
            col_d     = col_nx;
            cnt_d     = CNTW'(1);
          end
        end
      end
      ISSUE: begin
        if (op_q[2]) begin
          state_d = FIN;
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (32'(cnt_q) == N) begin
          state_d = DRAIN;
        end else begin
          re_d      = 1'b1;
          rd_addr_d = issue_addr;
          row_d     = row_nx;
          col_d     = col_nx;
          cnt_d     = cnt_q + CNTW'(1);
        end
      end
      DRAIN: begin
        // Pipeline empty: for element-wise ops the last write is on the bus now.
        if (vld_q == '0) begin
          if (op_q == OP_MAC) begin
            state_d   = ACCWR;
            we_d      = 1'b1;
            wr_addr_d = base_q;
            wr_data_d = scale(acc_q, shift_q, sat_q);
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      ACCWR: begin
        state_d = FIN;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      shift_q   <= '0;
      sat_q     <= 1'b0;
      base_q    <= '0;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      re_q      <= 1'b0;
      rd_addr_q <= '0;
      vld_q     <= '0;
      paddr_q   <= '{default: '0};
      acc_q     <= '0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      shift_q   <= shift_d;
      sat_q     <= sat_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      re_q      <= re_d;
      rd_addr_q <= rd_addr_d;
      vld_q     <= vld_d;
      paddr_q   <= paddr_d;
      acc_q     <= acc_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign sram_a_re   = re_q;
  assign sram_b_re   = re_q;
  assign sram_a_addr = rd_addr_q;
  assign sram_b_addr = rd_addr_q;
  assign sram_c_we   = we_q;
  assign sram_c_addr = wr_addr_q;
  assign sram_c_din  = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_tile_stream_engine.sv
// Testbench for tile_stream_engine: two instances (RD_LAT=1 and RD_LAT=3)
// share the input bus and a behavioural SRAM pair; a vector table drives
// whole operations, with hand-written start-while-busy and mid-op reset cases.
module tb_tile_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_v [2];
  logic [2:0] op_code, tile_i, tile_j;
  logic [3:0] shift;
  logic       sat_en;
  logic       a_re [2], b_re [2], c_we [2], busy [2], done [2], err [2];
  logic [9:0] a_addr [2], b_addr [2], c_addr [2];
  logic [7:0] a_dout [2], b_dout [2], c_din [2];
  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [1024];
  logic [7:0] pa [2][3];
  logic [7:0] pb [2][3];

  int passed = 0;
  int total  = 0;

  tile_stream_engine #(.DW(8), .AW(10), .TILE(4), .ROW_STRIDE(32), .RD_LAT(1), .TW(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op_code(op_code),
    .tile_i(tile_i), .tile_j(tile_j), .shift(shift), .sat_en(sat_en),
    .sram_a_re(a_re[0]), .sram_a_addr(a_addr[0]), .sram_a_dout(a_dout[0]),
    .sram_b_re(b_re[0]), .sram_b_addr(b_addr[0]), .sram_b_dout(b_dout[0]),
    .sram_c_we(c_we[0]), .sram_c_addr(c_addr[0]), .sram_c_din(c_din[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]));

  tile_stream_engine #(.DW(8), .AW(10), .TILE(4), .ROW_STRIDE(32), .RD_LAT(3), .TW(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op_code(op_code),
    .tile_i(tile_i), .tile_j(tile_j), .shift(shift), .sat_en(sat_en),
    .sram_a_re(a_re[1]), .sram_a_addr(a_addr[1]), .sram_a_dout(a_dout[1]),
    .sram_b_re(b_re[1]), .sram_b_addr(b_addr[1]), .sram_b_dout(b_dout[1]),
    .sram_c_we(c_we[1]), .sram_c_addr(c_addr[1]), .sram_c_din(c_din[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]));

  // SRAM read model: data appears RD_LAT cycles after re; 0x5A when idle.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pa[d][0] <= a_re[d] ? mem_a[a_addr[d]] : 8'h5A;
      pb[d][0] <= b_re[d] ? mem_b[b_addr[d]] : 8'h5A;
      pa[d][1] <= pa[d][0];
      pb[d][1] <= pb[d][0];
      pa[d][2] <= pa[d][1];
      pb[d][2] <= pb[d][1];
    end
  end
  assign a_dout[0] = pa[0][0];
  assign b_dout[0] = pb[0][0];
  assign a_dout[1] = pa[1][2];
  assign b_dout[1] = pb[1][2];

  typedef struct packed {
    int         lat;      // 0: RD_LAT=1 instance, 1: RD_LAT=3 instance
    logic [2:0] op;
    logic [2:0] ti;
    logic [2:0] tj;
    logic [3:0] sh;
    logic       sat;
    logic [7:0] a;
    logic [7:0] b;
    logic       ramp;     // A[element n] = n instead of a constant
    logic [7:0] exp_d;
    int         base;
    int         nwr;
    int         first_wr;
    int         done_c;
    logic       exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [9:0] eaddr(input int base, input int n);
    return 10'((base + (n / 4) * 32 + n % 4) % 1024);
  endfunction

  function automatic logic [63:0] outs(input int d);
    return 64'({a_re[d], b_re[d], a_addr[d], b_addr[d], c_we[d], c_addr[d],
                c_din[d], busy[d], done[d], err[d]});
  endfunction

  task automatic run(input int vi, input int pulse_k, input int rst_k);
    vec_t v;
    int d, nrd, nwr, ndone, done_k, busy_bad, stray, bad;
    v = vecs[vi];
    d = v.lat;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = v.a;
      mem_b[i] = v.b;
    end
    if (v.ramp) for (int n = 0; n < 16; n++) mem_a[eaddr(v.base, n)] = 8'(n);
    @(negedge clk);
    op_code = v.op; tile_i = v.ti; tile_j = v.tj; shift = v.sh; sat_en = v.sat;
    start_v[d] = 1'b1;
    @(posedge clk);
    nrd = 0; nwr = 0; ndone = 0; done_k = 0; busy_bad = 0; stray = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (a_re[d] !== b_re[d]) stray++;
      if (a_re[d]) begin
        chk("rd_cycle", 64'(k), 64'(nrd + 1));
        chk("rd_addr_a", 64'(a_addr[d]), 64'(eaddr(v.base, nrd)));
        chk("rd_addr_b", 64'(b_addr[d]), 64'(eaddr(v.base, nrd)));
        nrd++;
      end
      if (c_we[d]) begin
        chk("wr_cycle", 64'(k), 64'(v.first_wr + nwr));
        chk("wr_addr", 64'(c_addr[d]),
            64'(v.op == 3'd3 ? 10'(v.base) : eaddr(v.base, nwr)));
        chk("wr_data", 64'(c_din[d]), 64'(v.exp_d));
        nwr++;
      end
      if (done[d]) begin
        ndone++;
        if (done_k == 0) begin
          done_k = k;
          chk("done_cycle", 64'(k), 64'(v.done_c));
          chk("err_at_done", 64'(err[d]), 64'(v.exp_err));
          chk("busy_at_done", 64'(busy[d]), 64'(0));
        end
      end else if (err[d]) begin
        stray++;
      end
      if (done_k == 0 && !done[d] && busy[d] !== 1'b1) busy_bad++;
      if (k == 1) begin
        // Changes after acceptance must not affect the running operation.
        start_v[d] = 1'b0;
        op_code = 3'd6; tile_i = 3'd5; tile_j = 3'd5; shift = 4'hF; sat_en = ~v.sat;
      end
      if (pulse_k != 0 && k == pulse_k) begin
        start_v[d] = 1'b1;
        op_code = 3'd5;
      end
      if (pulse_k != 0 && k == pulse_k + 1) start_v[d] = 1'b0;
      if (rst_k != 0 && k == rst_k) begin
        rst_n = 1'b0;
        #1;
        chk("outputs_in_reset", outs(d), 64'(0));
        bad = 0;
        repeat (3) begin
          @(negedge clk);
          if (c_we[d] || a_re[d] || busy[d] || done[d]) bad++;
        end
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          if (c_we[d] || a_re[d] || busy[d] || done[d]) bad++;
        end
        chk("quiet_after_reset", 64'(bad), 64'(0));
        return;
      end
      if (done_k != 0 && k >= done_k + 3) break;
    end
    chk("done_seen", 64'(done_k != 0), 64'(1));
    chk("done_pulses", 64'(ndone), 64'(1));
    chk("read_count", 64'(nrd), 64'(v.exp_err ? 0 : 16));
    chk("write_count", 64'(nwr), 64'(v.nwr));
    chk("busy_until_done", 64'(busy_bad), 64'(0));
    chk("stray_err_or_re", 64'(stray), 64'(0));
  endtask

  initial begin
    //            lat op    ti    tj    sh    sat   a      b      ramp  exp    base nwr fw  dn  err
    vecs[0]  = '{0, 3'd0, 3'd1, 3'd2, 4'd0,  1'b0, 8'h10, 8'h10, 1'b0, 8'h20, 136, 16, 3,  19, 1'b0};
    vecs[1]  = '{0, 3'd2, 3'd0, 3'd0, 4'd4,  1'b1, 8'h64, 8'h64, 1'b0, 8'h7F, 0,   16, 3,  19, 1'b0};
    vecs[2]  = '{0, 3'd2, 3'd2, 3'd1, 4'd4,  1'b0, 8'h64, 8'h64, 1'b0, 8'h71, 260, 16, 3,  19, 1'b0};
    vecs[3]  = '{0, 3'd1, 3'd0, 3'd3, 4'd0,  1'b1, 8'h80, 8'h01, 1'b0, 8'h80, 12,  16, 3,  19, 1'b0};
    vecs[4]  = '{0, 3'd1, 3'd3, 3'd0, 4'd0,  1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 384, 16, 3,  19, 1'b0};
    vecs[5]  = '{0, 3'd0, 3'd0, 3'd1, 4'd0,  1'b1, 8'h7F, 8'h7F, 1'b0, 8'h7F, 4,   16, 3,  19, 1'b0};
    vecs[6]  = '{0, 3'd1, 3'd1, 3'd0, 4'd1,  1'b0, 8'hFD, 8'h00, 1'b0, 8'hFE, 128, 16, 3,  19, 1'b0};
    vecs[7]  = '{0, 3'd3, 3'd1, 3'd1, 4'd2,  1'b1, 8'h00, 8'h02, 1'b1, 8'h3C, 132, 1,  19, 20, 1'b0};
    vecs[8]  = '{0, 3'd3, 3'd2, 3'd2, 4'd11, 1'b0, 8'h80, 8'h80, 1'b0, 8'h80, 264, 1,  19, 20, 1'b0};
    vecs[9]  = '{1, 3'd5, 3'd0, 3'd0, 4'd0,  1'b0, 8'h01, 8'h01, 1'b0, 8'h00, 0,   0,  0,  2,  1'b1};
    vecs[10] = '{1, 3'd0, 3'd0, 3'd0, 4'd0,  1'b0, 8'h03, 8'hFB, 1'b0, 8'hFE, 0,   16, 5,  21, 1'b0};
    vecs[11] = '{1, 3'd3, 3'd3, 3'd3, 4'd0,  1'b1, 8'h01, 8'h01, 1'b0, 8'h10, 396, 1,  21, 22, 1'b0};
    vecs[12] = '{0, 3'd7, 3'd1, 3'd1, 4'd0,  1'b0, 8'h01, 8'h01, 1'b0, 8'h00, 0,   0,  0,  2,  1'b1};
    vecs[13] = '{0, 3'd2, 3'd0, 3'd2, 4'd0,  1'b1, 8'h80, 8'h7F, 1'b0, 8'h80, 8,   16, 3,  19, 1'b0};

    rst_n = 1'b0;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    op_code = '0; tile_i = '0; tile_j = '0; shift = '0; sat_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state_lat1", outs(0), 64'(0));
    chk("reset_state_lat3", outs(1), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int vi = 0; vi < 14; vi++) run(vi, 0, 0);

    // Start pulsed while busy on a MAC run: must be ignored.
    run(7, 5, 0);
    // Start pulsed while busy, then reset at cycle 8 of an ADD.
    run(0, 5, 8);
    // Fresh start after the abort completes normally.
    run(0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
